// File: rtl/mdu_pkg.sv
// Shared encodings and constants for the Minisys multiply/divide unit.
package mdu_pkg;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX,
      DONE
   } state_e;

   localparam int unsigned MDU_LATENCY = 34;

endpackage

// File: rtl/mdu_cond_negate.sv
// Conditional two's complement: passes the value through, or negates it when i_negate is set.
module mdu_cond_negate #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] i_value,
   input  logic             i_negate,
   output logic [WIDTH-1:0] o_value
);

   assign o_value = i_negate ? (~i_value + WIDTH'(1)) : i_value;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit: magnitudes are processed by a 32-step shift-add or
// restoring shift-subtract loop, then the signs are reapplied before HI/LO are written.
module mult_div_unit
   import mdu_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ITERS  = DATA_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [1:0]        op,
   input  logic [DATA_W-1:0] operand_a,
   input  logic [DATA_W-1:0] operand_b,
   output logic              busy,
   output logic              done,
   output logic              hi_lo_write,
   output logic [DATA_W-1:0] hi_out,
   output logic [DATA_W-1:0] lo_out,
   output logic              div_by_zero
);

   localparam int unsigned CNT_W = $clog2(ITERS);

   state_e              r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_is_div;
   logic                r_dbz;
   logic                r_neg_q;
   logic                r_neg_r;
   logic [DATA_W-1:0]   r_m;
   logic [DATA_W-1:0]   r_hi;
   logic [DATA_W-1:0]   r_lo;

   logic                w_is_div;
   logic                w_b_zero;
   logic                w_take_abs;
   logic [DATA_W-1:0]   w_abs_a;
   logic [DATA_W-1:0]   w_abs_b;
   logic [DATA_W:0]     w_sum;
   logic [DATA_W:0]     w_shift;
   logic                w_ge;
   logic [DATA_W-1:0]   w_diff;
   logic [2*DATA_W-1:0] w_prod_fix;
   logic [DATA_W-1:0]   w_rem_fix;
   logic [DATA_W-1:0]   w_quo_fix;

   assign w_is_div = (op == OP_DIV) || (op == OP_DIVU);
   assign w_b_zero = (operand_b == '0);
   // A signed divide by zero runs unsigned on the raw operands so HI ends up as raw operand_a.
   assign w_take_abs = ((op == OP_MULT) || (op == OP_DIV)) && !(w_is_div && w_b_zero);

   mdu_cond_negate #(.WIDTH(DATA_W)) u_abs_a (
      .i_value  (operand_a),
      .i_negate (w_take_abs & operand_a[DATA_W-1]),
      .o_value  (w_abs_a)
   );

   mdu_cond_negate #(.WIDTH(DATA_W)) u_abs_b (
      .i_value  (operand_b),
      .i_negate (w_take_abs & operand_b[DATA_W-1]),
      .o_value  (w_abs_b)
   );

   assign w_sum   = {1'b0, r_hi} + {1'b0, r_m};
   assign w_shift = {r_hi, r_lo[DATA_W-1]};
   assign w_ge    = (w_shift >= {1'b0, r_m});
   assign w_diff  = w_shift[DATA_W-1:0] - r_m;

   mdu_cond_negate #(.WIDTH(2*DATA_W)) u_fix_prod (
      .i_value  ({r_hi, r_lo}),
      .i_negate (r_neg_q),
      .o_value  (w_prod_fix)
   );

   mdu_cond_negate #(.WIDTH(DATA_W)) u_fix_rem (
      .i_value  (r_hi),
      .i_negate (r_neg_r),
      .o_value  (w_rem_fix)
   );

   mdu_cond_negate #(.WIDTH(DATA_W)) u_fix_quo (
      .i_value  (r_lo),
      .i_negate (r_neg_q),
      .o_value  (w_quo_fix)
   );

   assign hi_lo_write = done;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_is_div    <= 1'b0;
         r_dbz       <= 1'b0;
         r_neg_q     <= 1'b0;
         r_neg_r     <= 1'b0;
         r_m         <= '0;
         r_hi        <= '0;
         r_lo        <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         hi_out      <= '0;
         lo_out      <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_is_div <= w_is_div;
                  r_dbz    <= w_is_div & w_b_zero;
                  r_neg_q  <= w_take_abs & (operand_a[DATA_W-1] ^ operand_b[DATA_W-1]);
                  r_neg_r  <= w_take_abs & operand_a[DATA_W-1];
                  r_hi     <= '0;
                  r_cnt    <= '0;
                  // r_lo holds the operand consumed bit by bit, r_m the one added or subtracted.
                  if (w_is_div) begin
                     r_lo <= w_abs_a;
                     r_m  <= w_abs_b;
                  end else begin
                     r_lo <= w_abs_b;
                     r_m  <= w_abs_a;
                  end
                  busy    <= 1'b1;
                  r_state <= CALC;
               end
            end
            CALC: begin
               if (r_is_div) begin
                  r_hi <= w_ge ? w_diff : w_shift[DATA_W-1:0];
                  r_lo <= {r_lo[DATA_W-2:0], w_ge};
               end else if (r_lo[0]) begin
                  {r_hi, r_lo} <= {w_sum, r_lo[DATA_W-1:1]};
               end else begin
                  {r_hi, r_lo} <= {1'b0, r_hi, r_lo[DATA_W-1:1]};
               end
               if (r_cnt == CNT_W'(ITERS - 1)) begin
                  r_cnt   <= '0;
                  r_state <= FIX;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            FIX: begin
               if (r_is_div) begin
                  hi_out <= w_rem_fix;
                  lo_out <= w_quo_fix;
               end else begin
                  {hi_out, lo_out} <= w_prod_fix;
               end
               div_by_zero <= r_dbz;
               done        <= 1'b1;
               r_state     <= DONE;
            end
            DONE: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multi-cycle multiply/divide unit for the Minisys execute stage.
- Implements mult, multu, div and divu.
- Produces the 32-bit HI and LO results plus a one-cycle write strobe, which drive the decoder's HI/LO write inputs (write_HI_LO, ALU_HI, ALU_LO).
- Raises busy so the controller can stall the pipeline, and so mfhi/mflo cannot read stale HI/LO.

Parameters:
- DATA_W, 32, operand and result width; only 32 is supported.
- ITERS, DATA_W, number of shift iterations per operation.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request; sampled only when busy=0.
- op  input  2  operation: 00 mult, 01 multu, 10 div, 11 divu.
- operand_a  input  32  rs value (multiplicand or dividend).
- operand_b  input  32  rt value (multiplier or divisor).
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse when results are valid.
- hi_lo_write  output  1  equal to done; connects to write_HI_LO.
- hi_out  output  32  product[63:32] or remainder.
- lo_out  output  32  product[31:0] or quotient.
- div_by_zero  output  1  sticky for the last completed op: 1 if it was a div/divu with operand_b=0.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; busy=0, done=0, hi_lo_write=0, div_by_zero=0, hi_out=0, lo_out=0; iteration counter=0.
  - Reset mid-operation aborts immediately and produces no done pulse.
- States:
  - IDLE: if start=1, latch op, |a| and |b| (signed ops) or raw a and b (unsigned ops), plus the result signs. Next state CALC.
  - CALC: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle, ITERS cycles.
  - FIX: conditionally two's-complement the results; load hi_out/lo_out.
  - DONE: done=1 and hi_lo_write=1 for one cycle. Next state IDLE.
- Timing, with start sampled in cycle N:
  - busy=1 in cycles N+1 through N+34.
  - done=1 only in cycle N+34.
  - A new start is accepted from cycle N+35 onward.
  - start while busy=1 is ignored and does not queue.
- hi_out/lo_out hold their values between operations and change only on the FIX->DONE edge.
- Multiply:
  - 64-bit product; HI = product[63:32], LO = product[31:0].
  - Signed product is negated when a[31]^b[31].
- Divide:
  - Quotient sign = a[31]^b[31]; remainder sign = a[31], as on MIPS.
  - Signed overflow -2^31 / -1 gives LO=0x80000000, HI=0 (wrap, no trap).
- Divide by zero:
  - Result is LO=0xFFFFFFFF and HI=operand_a (raw).
  - div_by_zero=1; latency is unchanged (full 34 cycles).
- op changes after start have no effect.

Decomposition:
- Package mdu_pkg holds:
  - op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU;
  - state enum: IDLE, CALC, FIX, DONE;
  - MDU_LATENCY=34.
- One sub-module: mdu_cond_negate. It takes a width parameter, a value and a negate flag, and outputs the conditional two's complement. It is used for operand absolute values and for the final sign fix.

Test Plan:
1. multu a=7, b=6 -> done in cycle N+34, HI=0x00000000, LO=0x0000002A, busy high for exactly 34 cycles.
2. mult a=0x80000000, b=0x80000000 -> HI=0x40000000, LO=0x00000000. mult a=-3 (0xFFFFFFFD), b=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
3. div a=-7, b=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). divu a=0xFFFFFFFF, b=0x10 -> LO=0x0FFFFFFF, HI=0xF.
4. div a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0. divu a=123, b=0 -> LO=0xFFFFFFFF, HI=123, div_by_zero=1.
5. Start while busy: a second start at N+10 is ignored, exactly one done pulse occurs at N+34, and the results belong to the first op.
6. Reset asserted at cycle N+15 -> next cycle busy=0, hi_out=lo_out=0, no done pulse. A fresh start then completes normally 34 cycles later.
